// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive slice.
// Frame states, line levels and the default data width.
package uart_pkg;

  localparam int DEF_DATA_W = 8;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/uart_tick_edge.sv
// Turns the generator's half-bit square wave into a one-cycle
// bit_end strobe on every second toggle, independent of polarity.
module uart_tick_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick_i,
  output logic bit_end
);

  logic tick_q;
  logic phase_q;
  logic toggle;

  assign toggle  = tick_i ^ tick_q;
  assign bit_end = toggle & phase_q & ~clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q  <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      tick_q <= tick_i;
      if (clear)
        phase_q <= 1'b0;
      else if (toggle)
        phase_q <= ~phase_q;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer: start, LSB-first data, optional parity,
// one or two stop bits, paced by the baud generator tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic              parity_en_i,
  input  logic              parity_odd_i,
  input  logic              stop2_i,
  input  logic              tick_i,
  output logic              baud_en_o,
  output logic              txd_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_q, stop_d;
  logic              par_q, par_d;
  logic              pen_q, pen_d;
  logic              s2_q, s2_d;
  logic              txd_d;
  logic              busy_d;
  logic              done_d;
  logic              bit_end;

  uart_tick_edge u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == IDLE),
    .tick_i  (tick_i),
    .bit_end (bit_end)
  );

  assign tx_ready_o = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    par_d   = par_q;
    pen_d   = pen_q;
    s2_d    = s2_q;
    unique case (state_q)
      IDLE: begin
        if (tx_valid_i) begin
          state_d = START;
          shreg_d = tx_data_i;
          par_d   = ^tx_data_i ^ parity_odd_i;
          pen_d   = parity_en_i;
          s2_d    = stop2_i;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == LAST_IDX) begin
            state_d = pen_q ? PARITY : STOP;
            stop_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q == s2_q)
            state_d = IDLE;
          else
            stop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the state being entered so txd_o is a flop.
  always_comb begin
    txd_d = LINE_IDLE;
    unique case (state_d)
      IDLE:    txd_d = LINE_IDLE;
      START:   txd_d = START_BIT;
      DATA:    txd_d = shreg_d[0];
      PARITY:  txd_d = par_d;
      STOP:    txd_d = LINE_IDLE;
      default: txd_d = LINE_IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
      par_q     <= 1'b0;
      pen_q     <= 1'b0;
      s2_q      <= 1'b0;
      txd_o     <= LINE_IDLE;
      baud_en_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      stop_q    <= stop_d;
      par_q     <= par_d;
      pen_q     <= pen_d;
      s2_q      <= s2_d;
      txd_o     <= txd_d;
      baud_en_o <= busy_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a behavioural baud generator
// that restarts from zero whenever it is enabled.
module tb_uart_tx;

  logic       clk          = 1'b0;
  logic       rst_n        = 1'b0;
  logic [7:0] tx_data_i    = 8'h00;
  logic       tx_valid_i   = 1'b0;
  logic       parity_en_i  = 1'b0;
  logic       parity_odd_i = 1'b0;
  logic       stop2_i      = 1'b0;
  logic       tick         = 1'b0;
  logic       tx_ready_o;
  logic       baud_en_o;
  logic       txd_o;
  logic       busy_o;
  logic       done_o;

  int B    = 10;
  int gcnt = 0;
  int vecs = 0;
  int errs = 0;

  logic line_q [0:511];

  uart_tx #(.DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .stop2_i      (stop2_i),
    .tick_i       (tick),
    .baud_en_o    (baud_en_o),
    .txd_o        (txd_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  // Generator: holds tick while disabled, toggles every B/2 clocks.
  always @(posedge clk) begin
    if (baud_en_o !== 1'b1) begin
      gcnt <= 0;
    end else if (gcnt == B / 2 - 1) begin
      gcnt <= 0;
      tick <= ~tick;
    end else begin
      gcnt <= gcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] d, input logic pe,
                             input logic po, input logic s2,
                             input logic hold);
    @(negedge clk);
    tx_data_i    = d;
    parity_en_i  = pe;
    parity_odd_i = po;
    stop2_i      = s2;
    tx_valid_i   = 1'b1;
    @(negedge clk);
    chk("accept busy", busy_o, 1);
    chk("accept txd", txd_o, 0);
    if (!hold) tx_valid_i = 1'b0;
  endtask

  // Called at the negedge of the first START cycle.
  task automatic record_frame(input string tag, input logic [7:0] d,
                              input logic pe, input logic s2,
                              input logic ep, input int exp_done,
                              input int chg_at, input logic [7:0] chg_d);
    logic bits [0:15];
    int n, cyc, nbad, rdy, lo, hi;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (pe) begin bits[n] = ep; n++; end
    bits[n] = 1'b1; n++;
    if (s2) begin bits[n] = 1'b1; n++; end
    cyc = 0;
    rdy = 0;
    while (done_o !== 1'b1 && cyc < 400) begin
      line_q[cyc] = txd_o;
      if (tx_ready_o !== 1'b0) rdy++;
      if (cyc == chg_at) begin
        tx_data_i   = chg_d;
        parity_en_i = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("%s done cycle", tag), cyc, exp_done);
    for (int k = 0; k < n; k++) begin
      lo = (k == 0) ? 0 : B + 1 + (k - 1) * B;
      hi = B + k * B;
      nbad = 0;
      for (int c = lo; c <= hi; c++)
        if (line_q[c] !== bits[k]) nbad++;
      chk($sformatf("%s bit%0d bad clks", tag, k), nbad, 0);
    end
    chk($sformatf("%s ready during frame", tag), rdy, 0);
    chk($sformatf("%s end txd", tag), txd_o, 1);
    chk($sformatf("%s end baud_en", tag), baud_en_o, 0);
    chk($sformatf("%s end busy", tag), busy_o, 0);
    chk($sformatf("%s end ready", tag), tx_ready_o, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("rst txd", txd_o, 1);
      chk("rst baud_en", baud_en_o, 0);
      chk("rst ready", tx_ready_o, 1);
      chk("rst done", done_o, 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle txd", txd_o, 1);
      chk("idle baud_en", baud_en_o, 0);
      chk("idle done", done_o, 0);
    end

    B = 10;
    start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    record_frame("8N1 A5", 8'hA5, 1'b0, 1'b0, 1'b0, 101, -1, 8'h00);
    @(negedge clk);
    chk("done one cycle", done_o, 0);

    start_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    record_frame("8E1 07", 8'h07, 1'b1, 1'b0, 1'b1, 111, -1, 8'h00);
    start_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    record_frame("8O1 07", 8'h07, 1'b1, 1'b0, 1'b0, 111, -1, 8'h00);

    B = 4;
    start_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    record_frame("8N2 FF", 8'hFF, 1'b0, 1'b1, 1'b0, 45, -1, 8'h00);

    B = 10;
    start_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    record_frame("hs 55", 8'h55, 1'b0, 1'b0, 1'b0, 101, 30, 8'h33);
    chk("hs done", done_o, 1);
    @(negedge clk);
    chk("hs second busy", busy_o, 1);
    chk("hs second txd", txd_o, 0);
    chk("hs second done", done_o, 0);
    tx_valid_i = 1'b0;
    record_frame("hs 33", 8'h33, 1'b1, 1'b0, 1'b0, 111, -1, 8'h00);
    @(negedge clk);
    chk("hs no third", busy_o, 0);

    parity_en_i = 1'b0;
    start_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (45) @(negedge clk);
    chk("mid busy before rst", busy_o, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid rst txd", txd_o, 1);
    chk("mid rst baud_en", baud_en_o, 0);
    chk("mid rst busy", busy_o, 0);
    chk("mid rst done", done_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post rst done", done_o, 0);
      chk("post rst txd", txd_o, 1);
    end
    start_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    record_frame("after rst 3C", 8'h3C, 1'b0, 1'b0, 1'b0, 101, -1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
